// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch stage (IF) and
// the load/store stage (MEM). A granted request is latched and driven to the
// memory for LATENCY cycles. The read data is then returned with a one-cycle
// ready pulse to the requester that owned the access.
// Optional build macro ARB_ROUND_ROBIN_EN: when both stages request at once,
// the stage that did not own the previous access wins. Without the macro,
// MEM always has priority over IF.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_rdy_o,
    output logic [DATA_W-1:0] if_inst_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              mem_rdy_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              stallreq_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              grant;
    logic              grant_mem;
    logic              owner;        // 0 = IF, 1 = MEM
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] if_inst;
    logic [DATA_W-1:0] mem_data;
    logic              in_access;
    logic              in_resp;
    logic              last_beat;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;                // 0 = IF, 1 = MEM

    // Remember who owned the most recent access so a tie goes to the other side
    always_ff @(posedge clk) begin
        if (rst)
            last_owner <= 1'b0;
        else if (grant)
            last_owner <= grant_mem;
    end

    // MEM wins a tie only when IF owned the previous access
    assign grant_mem = mem_req_i & (!if_req_i | !last_owner);
`else
    // Fixed priority: MEM wins any tie
    assign grant_mem = mem_req_i;
`endif

    assign in_access = (state == ACCESS);
    assign in_resp   = (state == RESP);
    assign last_beat = in_access && (cnt == 4'd0);

    // Next-state logic: grant in IDLE, count down the access, one response cycle
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (if_req_i || mem_req_i) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
                    cnt_next   = 4'(LATENCY - 1);
                end
            end
            ACCESS: begin
                if (cnt == 4'd0)
                    state_next = RESP;
                else
                    cnt_next = cnt - 4'd1;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and access counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture the winning request; inputs are ignored until the next grant
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            owner     <= grant_mem;
            lat_we    <= grant_mem & mem_we_i;
            lat_addr  <= grant_mem ? mem_addr_i : if_addr_i;
            lat_wdata <= grant_mem ? mem_data_i : '0;
        end
    end

    // Sample memory read data into the owner's register on the last access beat;
    // a store leaves the load data register untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            if_inst  <= '0;
            mem_data <= '0;
        end else if (last_beat) begin
            if (!owner)
                if_inst <= ram_data_i;
            else if (!lat_we)
                mem_data <= ram_data_i;
        end
    end

    assign ram_ce_o   = in_access;
    assign ram_we_o   = in_access & lat_we;
    assign ram_addr_o = in_access ? lat_addr  : '0;
    assign ram_data_o = in_access ? lat_wdata : '0;

    assign if_rdy_o   = in_resp & !owner;
    assign mem_rdy_o  = in_resp &  owner;
    assign if_inst_o  = if_inst;
    assign mem_data_o = mem_data;

    // Stall while any active requester is not in its own response cycle
    assign stallreq_o = !rst &
                        ((if_req_i  & !(in_resp & !owner)) |
                         (mem_req_i & !(in_resp &  owner)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (default build, LATENCY = 2).
// Inputs are driven 1 ns after each rising edge. Outputs are checked at the same point.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_rdy_o;
    logic [DATA_W-1:0] if_inst_o;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_rdy_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              ram_ce_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_data_o;
    logic [DATA_W-1:0] ram_data_i;
    logic              stallreq_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdy_o   (if_rdy_o),
        .if_inst_o  (if_inst_o),
        .mem_req_i  (mem_req_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .mem_rdy_o  (mem_rdy_o),
        .mem_data_o (mem_data_o),
        .ram_ce_o   (ram_ce_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0004;
        mem_req_i  = 1'b0;
        mem_we_i   = 1'b0;
        mem_addr_i = '0;
        mem_data_i = '0;
        ram_data_i = 32'h3401_0020;

        // 1: reset with IF request held, then a single fetch
        step(); step();
        check("rst_ce",      ram_ce_o,   0);
        check("rst_we",      ram_we_o,   0);
        check("rst_addr",    ram_addr_o, 0);
        check("rst_wdata",   ram_data_o, 0);
        check("rst_if_rdy",  if_rdy_o,   0);
        check("rst_mem_rdy", mem_rdy_o,  0);
        check("rst_if_inst", if_inst_o,  0);
        check("rst_mem_dat", mem_data_o, 0);
        check("rst_stall",   stallreq_o, 0);
        rst = 1'b0;
        #1;
        check("t1_idle_stall", stallreq_o, 1);
        step();
        check("t1_a1_ce",   ram_ce_o,   1);
        check("t1_a1_addr", ram_addr_o, 32'h0000_0004);
        check("t1_a1_we",   ram_we_o,   0);
        check("t1_a1_rdy",  if_rdy_o,   0);
        step();
        check("t1_a2_ce",   ram_ce_o,   1);
        check("t1_a2_addr", ram_addr_o, 32'h0000_0004);
        step();
        check("t1_resp_ce",    ram_ce_o,   0);
        check("t1_resp_rdy",   if_rdy_o,   1);
        check("t1_resp_inst",  if_inst_o,  32'h3401_0020);
        check("t1_resp_stall", stallreq_o, 0);
        if_req_i = 1'b0;
        step();
        check("t1_idle_rdy", if_rdy_o, 0);
        check("t1_idle_ce",  ram_ce_o, 0);

        // 2: store only; later input changes must be ignored
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b1;
        mem_addr_i = 32'h0000_0100;
        mem_data_i = 32'hDEAD_BEEF;
        ram_data_i = 32'h1234_5678;
        step();
        check("t2_a1_ce",    ram_ce_o,   1);
        check("t2_a1_we",    ram_we_o,   1);
        check("t2_a1_addr",  ram_addr_o, 32'h0000_0100);
        check("t2_a1_wdata", ram_data_o, 32'hDEAD_BEEF);
        mem_addr_i = 32'h0000_0999;
        mem_data_i = 32'h0BAD_F00D;
        step();
        check("t2_a2_we",    ram_we_o,   1);
        check("t2_a2_addr",  ram_addr_o, 32'h0000_0100);
        check("t2_a2_wdata", ram_data_o, 32'hDEAD_BEEF);
        step();
        check("t2_resp_mrdy", mem_rdy_o,  1);
        check("t2_resp_irdy", if_rdy_o,   0);
        check("t2_resp_mdat", mem_data_o, 0);
        check("t2_resp_ce",   ram_ce_o,   0);
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
        step();
        check("t2_idle_mrdy", mem_rdy_o, 0);

        // 3: simultaneous requests, MEM first then IF, 8 cycles total
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0008;
        mem_req_i  = 1'b1;
        mem_addr_i = 32'h0000_0200;
        ram_data_i = 32'hAAAA_0001;
        #1;
        check("t3_c0_stall", stallreq_o, 1);
        step();
        check("t3_c1_addr",  ram_addr_o, 32'h0000_0200);
        check("t3_c1_we",    ram_we_o,   0);
        check("t3_c1_stall", stallreq_o, 1);
        step();
        step();
        check("t3_c3_mrdy",  mem_rdy_o,  1);
        check("t3_c3_irdy",  if_rdy_o,   0);
        check("t3_c3_mdat",  mem_data_o, 32'hAAAA_0001);
        check("t3_c3_stall", stallreq_o, 1);
        mem_req_i  = 1'b0;
        ram_data_i = 32'hBBBB_0002;
        step();
        check("t3_c4_stall", stallreq_o, 1);
        check("t3_c4_ce",    ram_ce_o,   0);
        step();
        check("t3_c5_addr",  ram_addr_o, 32'h0000_0008);
        check("t3_c5_ce",    ram_ce_o,   1);
        step();
        step();
        check("t3_c7_irdy",  if_rdy_o,   1);
        check("t3_c7_inst",  if_inst_o,  32'hBBBB_0002);
        check("t3_c7_stall", stallreq_o, 0);
        check("t3_c7_mdat",  mem_data_o, 32'hAAAA_0001);
        if_req_i = 1'b0;
        step();

        // 4: both held continuously, fixed priority keeps granting MEM
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_000C;
        mem_req_i  = 1'b1;
        mem_addr_i = 32'h0000_0300;
        ram_data_i = 32'hCCCC_0003;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("t4_acc%0d_addr", k), ram_addr_o, 32'h0000_0300);
            step();
            step();
            check($sformatf("t4_acc%0d_mrdy", k), mem_rdy_o,  1);
            check($sformatf("t4_acc%0d_irdy", k), if_rdy_o,   0);
            check($sformatf("t4_acc%0d_stl",  k), stallreq_o, 1);
            step();
        end
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
        step();
        step();

        // 5: reset during the second ACCESS cycle aborts, then re-serve
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0040;
        ram_data_i = 32'h5555_0005;
        step();
        check("t5_a1_ce", ram_ce_o, 1);
        step();
        rst = 1'b1;
        step();
        check("t5_abort_ce",   ram_ce_o,   0);
        check("t5_abort_rdy",  if_rdy_o,   0);
        check("t5_abort_stl",  stallreq_o, 0);
        check("t5_abort_inst", if_inst_o,  0);
        rst = 1'b0;
        step();
        check("t5_re_a1_ce",   ram_ce_o,   1);
        check("t5_re_a1_addr", ram_addr_o, 32'h0000_0040);
        step();
        check("t5_re_a2_rdy",  if_rdy_o,   0);
        step();
        check("t5_re_resp_rdy",  if_rdy_o,  1);
        check("t5_re_resp_inst", if_inst_o, 32'h5555_0005);
        if_req_i = 1'b0;
        step();
        check("t5_idle_rdy", if_rdy_o, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
